// File: rtl/stack_pointer_unit_if.sv
// Stack pointer control/status bundle between the CPU control logic and the
// stack pointer unit. The controller drives strobes and the data bus; the
// unit returns the pointer, the selected byte and its status flags.
interface stack_pointer_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  sp_inc;
  logic                  sp_dec;
  logic                  sp_load_low;
  logic                  sp_load_high;
  logic                  flag_clear;
  logic                  sp_byte_sel;
  logic [DATA_WIDTH-1:0] bus_in;
  logic [ADDR_WIDTH-1:0] sp_out;
  logic [DATA_WIDTH-1:0] sp_byte_out;
  logic                  sp_full;
  logic                  sp_empty;
  logic                  sp_overflow;
  logic                  sp_underflow;

  modport master (
    output sp_inc, sp_dec, sp_load_low, sp_load_high, flag_clear,
           sp_byte_sel, bus_in,
    input  sp_out, sp_byte_out, sp_full, sp_empty, sp_overflow, sp_underflow
  );

  modport slave (
    input  sp_inc, sp_dec, sp_load_low, sp_load_high, flag_clear,
           sp_byte_sel, bus_in,
    output sp_out, sp_byte_out, sp_full, sp_empty, sp_overflow, sp_underflow
  );
endinterface

// File: rtl/stack_pointer_unit.sv
// Full-descending hardware stack pointer for the SAP-2.0 CPU.
// PUSH decrements then writes at the new SP, POP reads at SP then increments.
// A 16-bit pointer is loaded from the 8-bit bus in two steps: the low byte
// is staged first, and the high-byte strobe commits both bytes at once.
// Bounds are checked only by equality with STACK_LIMIT (full) and STACK_TOP
// (empty); pointers outside that window wrap silently on inc/dec.
module stack_pointer_unit #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] STACK_TOP   = 16'h0200,
  parameter logic [ADDR_WIDTH-1:0] STACK_LIMIT = 16'h0100
) (
  input  logic                 clk,
  input  logic                 reset_n,
  stack_pointer_unit_if.slave  bus
);

  logic [ADDR_WIDTH-1:0] sp;
  logic [ADDR_WIDTH-1:0] sp_next;
  logic [DATA_WIDTH-1:0] stage_lo;
  logic [DATA_WIDTH-1:0] stage_lo_next;
  logic                  stage_valid;
  logic                  stage_valid_next;
  logic                  overflow;
  logic                  overflow_next;
  logic                  underflow;
  logic                  underflow_next;
  logic                  full;
  logic                  empty;

  assign full  = (sp == STACK_LIMIT);
  assign empty = (sp == STACK_TOP);

  // Next-state selection: load_high beats load_low beats inc/dec, and a
  // fault raised this cycle overrides a simultaneous flag_clear.
  always_comb begin
    sp_next          = sp;
    stage_lo_next    = stage_lo;
    stage_valid_next = stage_valid;
    overflow_next    = bus.flag_clear ? 1'b0 : overflow;
    underflow_next   = bus.flag_clear ? 1'b0 : underflow;

    if (bus.sp_load_high) begin
      sp_next          = {bus.bus_in, (stage_valid ? stage_lo : sp[DATA_WIDTH-1:0])};
      stage_valid_next = 1'b0;
    end else if (bus.sp_load_low) begin
      stage_lo_next    = bus.bus_in;
      stage_valid_next = 1'b1;
    end else if (bus.sp_inc && !bus.sp_dec) begin
      if (empty) begin
        underflow_next = 1'b1;
      end else begin
        sp_next = sp + ADDR_WIDTH'(1);
      end
    end else if (bus.sp_dec && !bus.sp_inc) begin
      if (full) begin
        overflow_next = 1'b1;
      end else begin
        sp_next = sp - ADDR_WIDTH'(1);
      end
    end
  end

  // State registers; reset drops any staged low byte and returns to empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp          <= STACK_TOP;
      stage_lo    <= '0;
      stage_valid <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      sp          <= sp_next;
      stage_lo    <= stage_lo_next;
      stage_valid <= stage_valid_next;
      overflow    <= overflow_next;
      underflow   <= underflow_next;
    end
  end

  // Status and byte-select outputs are combinational views of the state.
  always_comb begin
    bus.sp_out       = sp;
    bus.sp_byte_out  = bus.sp_byte_sel ? sp[ADDR_WIDTH-1 -: DATA_WIDTH] : sp[DATA_WIDTH-1:0];
    bus.sp_full      = full;
    bus.sp_empty     = empty;
    bus.sp_overflow  = overflow;
    bus.sp_underflow = underflow;
  end

endmodule
